// File: rtl/wb_interconnect_rr_nxm.sv
// -----------------------------------------------------------------------------
// wb_interconnect_rr_nxm
// Wishbone B4 classic crossbar: N_MASTERS initiators to N_SLAVES targets.
// Each slave has a round-robin arbiter. A grant stays locked for the whole
// CYC of the winning master. Addresses are decoded against inclusive
// base/limit windows, where the lowest matching slave wins. Unmapped strobes
// get a one-cycle ERR from a built-in responder.
//
// Optional feature: define WB_IC_TIMEOUT_EN to add a per-slave response
// watchdog. A stalled access is then terminated with ERR after
// TIMEOUT_CYCLES cycles.
//
// Ports (all vectors packed, element k at slice k):
//   clk_i, rst_i              clock, synchronous active-high reset
//   m_adr_i .. m_we_i         master requests (adr/dat_w/sel/cti/bte/cyc/stb/we)
//   m_dat_r_o/m_ack_o/m_err_o responses to each master
//   s_adr_o .. s_we_o         requests forwarded to each slave
//   s_dat_r_i/s_ack_i/s_err_i responses from each slave
// -----------------------------------------------------------------------------
module wb_interconnect_rr_nxm #(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned N_SLAVES       = 4,
  parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE  = '0,
  parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_LIMIT = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_adr_i,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_dat_w_i,
  input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [N_MASTERS*3-1:0]             m_cti_i,
  input  logic [N_MASTERS*2-1:0]             m_bte_i,
  input  logic [N_MASTERS-1:0]               m_cyc_i,
  input  logic [N_MASTERS-1:0]               m_stb_i,
  input  logic [N_MASTERS-1:0]               m_we_i,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_dat_r_o,
  output logic [N_MASTERS-1:0]               m_ack_o,
  output logic [N_MASTERS-1:0]               m_err_o,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]  s_adr_o,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]  s_dat_w_o,
  output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0] s_sel_o,
  output logic [N_SLAVES*3-1:0]              s_cti_o,
  output logic [N_SLAVES*2-1:0]              s_bte_o,
  output logic [N_SLAVES-1:0]                s_cyc_o,
  output logic [N_SLAVES-1:0]                s_stb_o,
  output logic [N_SLAVES-1:0]                s_we_o,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]  s_dat_r_i,
  input  logic [N_SLAVES-1:0]                s_ack_i,
  input  logic [N_SLAVES-1:0]                s_err_i
);

  localparam int unsigned AW  = WB_ADDR_WIDTH;
  localparam int unsigned DW  = WB_DATA_WIDTH;
  localparam int unsigned SW  = WB_DATA_WIDTH / 8;
  localparam int unsigned MW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned SIW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_e;

  state_e         state_q [N_SLAVES];
  state_e         state_d [N_SLAVES];
  logic [MW-1:0]  owner_q [N_SLAVES];
  logic [MW-1:0]  owner_d [N_SLAVES];
  logic [MW-1:0]  ptr_q   [N_SLAVES];
  logic [MW-1:0]  ptr_d   [N_SLAVES];
  logic [N_MASTERS-1:0] err_q;
  logic [N_MASTERS-1:0] err_d;

  logic [N_MASTERS-1:0] req_s;
  logic [N_MASTERS-1:0] dec_hit_s;
  logic [SIW-1:0]       dec_idx_s [N_MASTERS];
  logic [N_MASTERS-1:0] busy_s;
  logic [N_SLAVES-1:0]  tmo_s;

  assign req_s = m_cyc_i & m_stb_i;

  // Address decode: iterate downwards so the lowest matching slave wins.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      dec_hit_s[i] = 1'b0;
      dec_idx_s[i] = '0;
      for (int j = N_SLAVES - 1; j >= 0; j--) begin
        if ((m_adr_i[i*AW +: AW] >= SLAVE_BASE[j*AW +: AW]) &&
            (m_adr_i[i*AW +: AW] <= SLAVE_LIMIT[j*AW +: AW])) begin
          dec_hit_s[i] = 1'b1;
          dec_idx_s[i] = SIW'(j);
        end else begin
          dec_hit_s[i] = dec_hit_s[i];
        end
      end
    end
  end

  // Masters that already own a slave. They cannot win a second grant until
  // the current one is released.
  always_comb begin
    busy_s = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if ((state_q[j] == S_GRANTED) && (owner_q[j] == MW'(i))) begin
          busy_s[i] = 1'b1;
        end else begin
          busy_s[i] = busy_s[i];
        end
      end
    end
  end

`ifdef WB_IC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q [N_SLAVES];
  logic [TW-1:0] cnt_d [N_SLAVES];

  // Watchdog: count stalled strobe cycles of a granted slave.
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      tmo_s[j] = (state_q[j] == S_GRANTED) && (cnt_q[j] == TW'(TIMEOUT_CYCLES));
      if ((state_q[j] != S_GRANTED) || s_ack_i[j] || s_err_i[j] || tmo_s[j]) begin
        cnt_d[j] = '0;
      end else if (m_stb_i[owner_q[j]]) begin
        cnt_d[j] = cnt_q[j] + TW'(1);
      end else begin
        cnt_d[j] = cnt_q[j];
      end
    end
  end

  // Watchdog counter registers.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N_SLAVES; j++) begin
      if (rst_i) begin
        cnt_q[j] <= '0;
      end else begin
        cnt_q[j] <= cnt_d[j];
      end
    end
  end
`else
  // Keeps the limit parameter referenced in builds without the watchdog.
  logic unused_tmo_s;
  assign unused_tmo_s = ^TIMEOUT_CYCLES;
  assign tmo_s        = '0;
`endif

  // Per-slave arbitration FSM: next state, owner and round-robin pointer.
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      logic          found;
      logic [MW-1:0] ci;
      logic [MW-1:0] own;
      int unsigned   cand;
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      found      = 1'b0;
      ci         = '0;
      cand       = 0;
      own        = owner_q[j];
      case (state_q[j])
        S_IDLE: begin
          // Search starts one past the last winner.
          for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = (32'(ptr_q[j]) + k) % N_MASTERS;
            ci   = MW'(cand);
            if (!found && req_s[ci] && dec_hit_s[ci] &&
                (dec_idx_s[ci] == SIW'(j)) && !busy_s[ci]) begin
              found      = 1'b1;
              state_d[j] = S_GRANTED;
              owner_d[j] = ci;
              ptr_d[j]   = ci;
            end else begin
              found = found;
            end
          end
        end
        S_GRANTED: begin
          // Release on CYC drop, on a strobe aimed elsewhere, or on watchdog.
          if (!m_cyc_i[own] ||
              (m_stb_i[own] && (!dec_hit_s[own] || (dec_idx_s[own] != SIW'(j)))) ||
              tmo_s[j]) begin
            state_d[j] = S_IDLE;
          end else begin
            state_d[j] = S_GRANTED;
          end
        end
        default: begin
          state_d[j] = S_IDLE;
        end
      endcase
    end
  end

  // Unmapped responder: ERR one cycle after the strobe, then one forced-low cycle.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      err_d[i] = req_s[i] & ~dec_hit_s[i] & ~err_q[i];
    end
  end

  // Arbitration state and unmapped-error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        state_q[j] <= S_IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= MW'(N_MASTERS - 1);
      end
      err_q <= '0;
    end else begin
      for (int j = 0; j < N_SLAVES; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
      err_q <= err_d;
    end
  end

  // Crossbar datapath: forward the owner's request and route the response back.
  always_comb begin
    s_adr_o   = '0;
    s_dat_w_o = '0;
    s_sel_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    s_we_o    = '0;
    m_dat_r_o = '0;
    m_ack_o   = '0;
    m_err_o   = err_q;
    for (int j = 0; j < N_SLAVES; j++) begin
      logic [MW-1:0] own;
      int unsigned   oi;
      own = owner_q[j];
      oi  = 32'(owner_q[j]);
      if (state_q[j] == S_GRANTED) begin
        s_adr_o[j*AW +: AW]   = m_adr_i[oi*AW +: AW];
        s_dat_w_o[j*DW +: DW] = m_dat_w_i[oi*DW +: DW];
        s_sel_o[j*SW +: SW]   = m_sel_i[oi*SW +: SW];
        s_cti_o[j*3 +: 3]     = m_cti_i[oi*3 +: 3];
        s_bte_o[j*2 +: 2]     = m_bte_i[oi*2 +: 2];
        s_we_o[j]             = m_we_i[own];
        s_cyc_o[j]            = m_cyc_i[own] & ~tmo_s[j];
        s_stb_o[j]            = m_stb_i[own] & ~tmo_s[j];
        m_dat_r_o[oi*DW +: DW] = m_dat_r_o[oi*DW +: DW] | s_dat_r_i[j*DW +: DW];
        m_ack_o[own]          = m_ack_o[own] | (s_ack_i[j] & ~tmo_s[j]);
        m_err_o[own]          = m_err_o[own] | s_err_i[j] | tmo_s[j];
      end else begin
        s_cyc_o[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_interconnect_rr_nxm.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for wb_interconnect_rr_nxm (2 masters, 4 slaves).
// Slave windows: s0 0x0000-0x0FFF, s1 0x1000-0x1FFF, s2 0x2000-0x2FFF,
// s3 0x3000-0x3FFF. Inputs change 1 ns after the rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_interconnect_rr_nxm;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NM*32-1:0] m_adr_i, m_dat_w_i, m_dat_r_o;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o;
  logic [NS*32-1:0] s_adr_o, s_dat_w_o, s_dat_r_i;
  logic [NS*4-1:0]  s_sel_o;
  logic [NS*3-1:0]  s_cti_o;
  logic [NS*2-1:0]  s_bte_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;

  int checks = 0;
  int errors = 0;

  wb_interconnect_rr_nxm #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .N_MASTERS     (NM),
    .N_SLAVES      (NS),
    .SLAVE_BASE    ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_LIMIT   ({32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m_adr_i  (m_adr_i),
    .m_dat_w_i(m_dat_w_i),
    .m_sel_i  (m_sel_i),
    .m_cti_i  (m_cti_i),
    .m_bte_i  (m_bte_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_dat_r_o(m_dat_r_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_w_o(s_dat_w_o),
    .s_sel_o  (s_sel_o),
    .s_cti_o  (s_cti_o),
    .s_bte_o  (s_bte_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_dat_r_i(s_dat_r_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic set_m(input int m, input logic [31:0] adr, input logic req);
    m_adr_i[m*32 +: 32] = adr;
    m_sel_i[m*4 +: 4]   = 4'hF;
    m_cyc_i[m]          = req;
    m_stb_i[m]          = req;
  endtask

  task automatic set_s(input int s, input logic ack, input logic [31:0] dat);
    s_ack_i[s]            = ack;
    s_dat_r_i[s*32 +: 32] = dat;
  endtask

  initial begin
    logic [1:0] exp_err;
    rst_i     = 1'b1;
    m_adr_i   = '0;
    m_dat_w_i = '0;
    m_sel_i   = '0;
    m_cti_i   = '0;
    m_bte_i   = '0;
    m_cyc_i   = '0;
    m_stb_i   = '0;
    m_we_i    = '0;
    s_dat_r_i = '0;
    s_ack_i   = '0;
    s_err_i   = '0;

    // Reset state
    step(); step(); settle();
    check_val("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    check_val("rst_s_stb", 64'(s_stb_o), 64'h0);
    check_val("rst_m_ack", 64'(m_ack_o), 64'h0);
    check_val("rst_m_err", 64'(m_err_o), 64'h0);
    check_val("rst_m_dat", m_dat_r_o, 64'h0);
    step();
    rst_i = 1'b0;

    // Basic read of slave 2
    set_m(0, 32'h0000_2004, 1'b1);
    settle();
    check_val("t1_latency", 64'(s_cyc_o), 64'h0);
    step();
    set_s(2, 1'b1, 32'hDEAD_BEEF);
    settle();
    check_val("t1_s_cyc", 64'(s_cyc_o), 64'h4);
    check_val("t1_s_adr2", 64'(s_adr_o[2*32 +: 32]), 64'h2004);
    check_val("t1_m_ack", 64'(m_ack_o), 64'h1);
    check_val("t1_m_dat0", 64'(m_dat_r_o[31:0]), 64'hDEAD_BEEF);
    check_val("t1_m_dat1", 64'(m_dat_r_o[63:32]), 64'h0);
    step();
    set_m(0, 32'h0, 1'b0);
    set_s(2, 1'b0, 32'h0);
    settle();
    check_val("t1_release", 64'(s_cyc_o), 64'h0);
    step();

    // Round-robin contention on slave 1
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    set_m(0, 32'h0000_1000, 1'b1);
    set_m(1, 32'h0000_1004, 1'b1);
    settle();
    check_val("t2_latency", 64'(s_cyc_o), 64'h0);
    step();
    set_s(1, 1'b1, 32'h1111_1111);
    settle();
    check_val("t2_first_cyc", 64'(s_cyc_o), 64'h2);
    check_val("t2_first_adr", 64'(s_adr_o[1*32 +: 32]), 64'h1000);
    check_val("t2_first_ack", 64'(m_ack_o), 64'h1);
    check_val("t2_loser_dat", 64'(m_dat_r_o[63:32]), 64'h0);
    step();
    set_m(0, 32'h0, 1'b0);
    set_s(1, 1'b0, 32'h0);
    settle();
    check_val("t2_drop", 64'(s_cyc_o), 64'h0);
    step();
    settle();
    check_val("t2_gap", 64'(s_cyc_o), 64'h0);
    step();
    set_s(1, 1'b1, 32'h2222_2222);
    settle();
    check_val("t2_second_adr", 64'(s_adr_o[1*32 +: 32]), 64'h1004);
    check_val("t2_second_ack", 64'(m_ack_o), 64'h2);
    check_val("t2_second_dat", 64'(m_dat_r_o[63:32]), 64'h2222_2222);
    step();
    set_m(1, 32'h0, 1'b0);
    set_s(1, 1'b0, 32'h0);
    step();
    set_m(0, 32'h0000_1008, 1'b1);
    set_m(1, 32'h0000_100C, 1'b1);
    step();
    settle();
    check_val("t2_third_adr", 64'(s_adr_o[1*32 +: 32]), 64'h1008);
    check_val("t2_third_cyc", 64'(s_cyc_o), 64'h2);
    step();
    set_m(0, 32'h0, 1'b0);
    set_m(1, 32'h0, 1'b0);
    step();
    step();

    // Locked 4-beat burst by M1 on slave 0 while M0 contends
    set_m(1, 32'h0000_0100, 1'b1);
    step();
    set_m(0, 32'h0000_0200, 1'b1);
    for (int b = 0; b < 4; b++) begin
      set_m(1, 32'h0000_0100 + 32'(4 * b), 1'b1);
      set_s(0, 1'b1, 32'h0000_00A0 + 32'(b));
      settle();
      check_val("t3_beat_adr", 64'(s_adr_o[31:0]), 64'h100 + 64'(4 * b));
      check_val("t3_beat_ack", 64'(m_ack_o), 64'h2);
      step();
    end
    set_m(1, 32'h0, 1'b0);
    set_s(0, 1'b0, 32'h0);
    settle();
    check_val("t3_end_ack", 64'(m_ack_o), 64'h0);
    check_val("t3_end_cyc", 64'(s_cyc_o), 64'h0);
    step();
    settle();
    check_val("t3_gap_cyc", 64'(s_cyc_o), 64'h0);
    step();
    set_s(0, 1'b1, 32'h0000_00B0);
    settle();
    check_val("t3_m0_adr", 64'(s_adr_o[31:0]), 64'h200);
    check_val("t3_m0_ack", 64'(m_ack_o), 64'h1);
    check_val("t3_m0_dat", 64'(m_dat_r_o[31:0]), 64'hB0);
    step();
    set_m(0, 32'h0, 1'b0);
    set_s(0, 1'b0, 32'h0);
    step();
    step();

    // Unmapped access with STB held four cycles
    for (int n = 0; n < 4; n++) begin
      set_m(0, 32'hF000_0000, 1'b1);
      exp_err = ((n % 2) == 1) ? 2'b01 : 2'b00;
      settle();
      check_val("t4_err", 64'(m_err_o), 64'(exp_err));
      check_val("t4_no_cyc", 64'(s_cyc_o), 64'h0);
      check_val("t4_no_ack", 64'(m_ack_o), 64'h0);
      step();
    end
    set_m(0, 32'h0, 1'b0);
    settle();
    check_val("t4_err_end", 64'(m_err_o), 64'h0);
    step();

    // Reset in the middle of a burst
    set_m(1, 32'h0000_2000, 1'b1);
    step();
    set_s(2, 1'b1, 32'h0000_00C0);
    settle();
    check_val("t5_pre_ack", 64'(m_ack_o), 64'h2);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    set_m(0, 32'h0000_2008, 1'b1);
    settle();
    check_val("t5_rst_cyc", 64'(s_cyc_o), 64'h0);
    check_val("t5_rst_ack", 64'(m_ack_o), 64'h0);
    step();
    set_s(2, 1'b0, 32'h0);
    settle();
    check_val("t5_m0_wins", 64'(s_adr_o[2*32 +: 32]), 64'h2008);
    check_val("t5_m0_cyc", 64'(s_cyc_o), 64'h4);
    step();
    set_m(0, 32'h0, 1'b0);
    set_m(1, 32'h0, 1'b0);
    step();
    step();

`ifdef WB_IC_TIMEOUT_EN
    // Watchdog on slave 3, which never responds
    set_m(0, 32'h0000_3000, 1'b1);
    step();
    for (int n = 0; n <= 8; n++) begin
      settle();
      if (n < 8) begin
        check_val("t6_wait_err", 64'(m_err_o), 64'h0);
        check_val("t6_wait_stb", 64'(s_stb_o), 64'h8);
      end else begin
        check_val("t6_tmo_err", 64'(m_err_o), 64'h1);
        check_val("t6_tmo_cyc", 64'(s_cyc_o), 64'h0);
      end
      step();
    end
    set_m(0, 32'h0, 1'b0);
    step();
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_rr_nxm.md
# wb_interconnect_rr_nxm

Parametrised Wishbone (classic, B4) crossbar connecting N_MASTERS initiators to N_SLAVES targets through flattened port vectors. It provides per-slave round-robin arbitration with grant locking for the full CYC, inclusive base/limit address decode, and a built-in error responder for unmapped addresses. An optional per-slave response watchdog can be compiled in. It replaces the fixed-size wrapper interconnects at the top of SoC fabrics.

## Interface
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width; byte-select width is WB_DATA_WIDTH/8
- N_MASTERS, 2, number of masters (1..8)
- N_SLAVES, 4, number of slaves (1..16)
- SLAVE_BASE, 0, packed N_SLAVES*WB_ADDR_WIDTH; slave i base in bits [i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]
- SLAVE_LIMIT, 0, same packing; inclusive upper bound
- TIMEOUT_CYCLES, 255, watchdog limit (used only with WB_IC_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we  in  N_MASTERS x field width, packed; master i at slice i
- m_dat_r, m_ack, m_err  out  N_MASTERS x field width; responses to master i
- s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we  out  N_SLAVES x field width; requests to slave j
- s_dat_r, s_ack, s_err  in  N_SLAVES x field width; responses from slave j

## Operation
- Decode: master i targets slave j when SLAVE_BASE[j] <= m_adr[i] <= SLAVE_LIMIT[j]. Lowest matching j wins. No match means unmapped.
- Request: m_cyc[i] & m_stb[i] with a decode to j.
- Per-slave FSM IDLE/GRANTED:
  - IDLE -> GRANTED when any request targets j. The winner is the first requester at or after ptr[j]+1 (mod N_MASTERS). At grant, ptr[j] is set to the winner.
  - GRANTED -> IDLE when the granted master's m_cyc falls.
  - GRANTED -> IDLE when the granted master asserts m_stb with an address decoding to a different slave or to unmapped.
  - With WB_IC_TIMEOUT_EN: GRANTED -> IDLE on timeout.
- While GRANTED, the master's adr/dat_w/sel/cti/bte/we/cyc/stb are forwarded to slave j. The slave's dat_r/ack/err are routed combinationally to that master.
- When no slave is granted to a master, m_ack and m_err are 0 and m_dat_r is 0. When a slave is IDLE, all its outputs are 0.
- A master holds at most one grant. Locked grants persist across multiple STB cycles inside one CYC, so RMW and bursts are atomic.
- Unmapped request: m_err[i] pulses for exactly one cycle, the cycle after the request is sampled, then is forced low for one cycle. Back-to-back unmapped strobes therefore receive ERR every other cycle. m_ack[i] stays 0.
- Reset mid-transaction: all grants drop on the same edge; s_cyc/s_stb go 0 the cycle after rst is sampled high.

## Timing
- Arbitration latency: 1 cycle. A request sampled at edge k gives s_cyc/s_stb high after edge k.
- Grant persistence: s_cyc remains high across consecutive locked CYCs only if m_cyc never falls. A drop of m_cyc for one cycle releases the grant and re-arbitrates.
- Response path: s_ack/s_err/s_dat_r to m_* are purely combinational, adding zero cycles.
- Simultaneous requests to one slave: one grant per arbitration. Losers see no ack and stall with STB held.
- Simultaneous release and new request to the same slave: release at edge k, new grant at edge k+1. Grant switch costs 1 idle cycle.
- Reset values:
  - All s_* outputs and m_ack/m_err/m_dat_r: 0.
  - FSMs: IDLE.
  - ptr[j] = N_MASTERS-1, so master 0 wins the first contention.

## Configuration
- WB_IC_TIMEOUT_EN defined:
  - Each slave gets a counter of width $clog2(TIMEOUT_CYCLES+1). It increments on each GRANTED cycle with s_stb=1 and s_ack=s_err=0, and clears on ack/err or IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the granted master gets a one-cycle m_err, s_cyc/s_stb are forced 0 that cycle, and the FSM returns to IDLE.
- Undefined: no counter. A slave that never responds stalls its master indefinitely.

## Test plan
- N_MASTERS=2, N_SLAVES=4, slave 2 at 0x2000-0x2FFF. M0 reads 0x2004, slave returns ack and 0xDEADBEEF one cycle later -> m_ack[0]=1 and m_dat_r[0]=0xDEADBEEF the same cycle; s_adr[2]=0x2004.
- M0 and M1 both request slave 1 from reset -> M0 is granted first; after M0 drops CYC, M1 is granted next with a 1-cycle gap; a third contention goes to M0.
- M1 issues a 4-beat locked burst (CYC held) while M0 contends -> M0 sees no ack until M1's CYC falls.
- M0 accesses unmapped 0xF0000000 with STB held for 4 cycles -> m_err[0] pattern 0,1,0,1; all s_cyc remain 0.
- With WB_IC_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 3 never acks -> m_err pulses exactly 8 cycles after s_stb rises; s_cyc[3] falls the same cycle.
- rst asserted mid-burst -> the next cycle all s_cyc=0 and m_ack=0; after release, M0 wins the first contention.
